// File: rtl/mult_div_unit_if.sv
// Start/done handshake and result bus between the control unit and the HI/LO multiply/divide unit.
interface mult_div_unit_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic             op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             busy;
   logic             done;
   logic             div0;

   modport master (
      output start, op, a, b,
      input  hi, lo, busy, done, div0
   );

   modport slave (
      input  start, op, a, b,
      output hi, lo, busy, done, div0
   );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring on magnitudes) producing HI/LO.
// state  | meaning
// S_IDLE | waiting for start; divide-by-zero answered here in one cycle
// S_RUN  | WIDTH iterations of Booth step or restoring-divide step
// S_FIX  | sign correction, HI/LO load, done pulse
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic           clock_i,
   input  logic           reset_i,
   mult_div_unit_if.slave bus
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_e;

   state_e           state_q;
   logic             op_q;
   logic             qm1_q;
   logic             neg_quot_q;
   logic             neg_rem_q;
   logic             busy_q;
   logic             done_q;
   logic             div0_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH:0]   acc_q;
   logic [WIDTH:0]   opd_q;
   logic [WIDTH-1:0] mq_q;
   logic [WIDTH-1:0] hi_q;
   logic [WIDTH-1:0] lo_q;

   logic [WIDTH:0]   acc_d;
   logic [WIDTH-1:0] mq_d;
   logic             qm1_d;
   logic [WIDTH-1:0] hi_d;
   logic [WIDTH-1:0] lo_d;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic [WIDTH:0]   booth_sum;
   logic [WIDTH:0]   rem_sh;
   logic             rem_ge;

   // acc carries one guard bit so subtracting the most-negative multiplicand cannot overflow
   always_comb begin
      a_mag     = bus.a[WIDTH-1] ? -bus.a : bus.a;
      b_mag     = bus.b[WIDTH-1] ? -bus.b : bus.b;
      booth_sum = acc_q;
      case ({mq_q[0], qm1_q})
         2'b01:   booth_sum = acc_q + opd_q;
         2'b10:   booth_sum = acc_q - opd_q;
         default: booth_sum = acc_q;
      endcase
      rem_sh = {acc_q[WIDTH-1:0], mq_q[WIDTH-1]};
      rem_ge = (rem_sh >= opd_q);
      if (op_q) begin
         acc_d = rem_ge ? (rem_sh - opd_q) : rem_sh;
         mq_d  = {mq_q[WIDTH-2:0], rem_ge};
         qm1_d = 1'b0;
         lo_d  = neg_quot_q ? -mq_q : mq_q;
         hi_d  = neg_rem_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      end else begin
         acc_d = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
         mq_d  = {booth_sum[0], mq_q[WIDTH-1:1]};
         qm1_d = mq_q[0];
         lo_d  = mq_q;
         hi_d  = acc_q[WIDTH-1:0];
      end
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q    <= S_IDLE;
         op_q       <= 1'b0;
         qm1_q      <= 1'b0;
         neg_quot_q <= 1'b0;
         neg_rem_q  <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         div0_q     <= 1'b0;
         cnt_q      <= '0;
         acc_q      <= '0;
         opd_q      <= '0;
         mq_q       <= '0;
         hi_q       <= '0;
         lo_q       <= '0;
      end else begin
         done_q <= 1'b0;
         div0_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  if (bus.op && (bus.b == '0)) begin
                     done_q <= 1'b1;
                     div0_q <= 1'b1;
                  end else begin
                     op_q    <= bus.op;
                     cnt_q   <= '0;
                     busy_q  <= 1'b1;
                     acc_q   <= '0;
                     qm1_q   <= 1'b0;
                     state_q <= S_RUN;
                     if (bus.op) begin
                        mq_q       <= a_mag;
                        opd_q      <= {1'b0, b_mag};
                        neg_quot_q <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                        neg_rem_q  <= bus.a[WIDTH-1];
                     end else begin
                        mq_q  <= bus.b;
                        opd_q <= {bus.a[WIDTH-1], bus.a};
                     end
                  end
               end
            end
            S_RUN: begin
               acc_q <= acc_d;
               mq_q  <= mq_d;
               qm1_q <= qm1_d;
               cnt_q <= cnt_q + CW'(1);
               if (cnt_q == CW'(WIDTH - 1)) state_q <= S_FIX;
            end
            S_FIX: begin
               hi_q    <= hi_d;
               lo_q    <= lo_d;
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.div0 = div0_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit at WIDTH=32 and WIDTH=8 against a plain-arithmetic signed reference model.
module tb_mult_div_unit;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] exp_hi [2];
   logic [31:0] exp_lo [2];

   always #5 clk = ~clk;

   mult_div_unit_if #(.WIDTH(32)) bus32 ();
   mult_div_unit_if #(.WIDTH(8))  bus8 ();

   mult_div_unit #(.WIDTH(32)) u_dut32 (.clock_i(clk), .reset_i(rst), .bus(bus32));
   mult_div_unit #(.WIDTH(8))  u_dut8  (.clock_i(clk), .reset_i(rst), .bus(bus8));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int w, input bit st, input bit op, input logic [31:0] a,
                        input logic [31:0] b);
      if (w == 32) begin
         bus32.start = st; bus32.op = op; bus32.a = a; bus32.b = b;
      end else begin
         bus8.start = st; bus8.op = op; bus8.a = a[7:0]; bus8.b = b[7:0];
      end
   endtask

   task automatic rd(input int w, output logic [31:0] hi, output logic [31:0] lo,
                     output logic busy, output logic done, output logic div0);
      if (w == 32) begin
         hi = bus32.hi; lo = bus32.lo; busy = bus32.busy; done = bus32.done; div0 = bus32.div0;
      end else begin
         hi = {24'h0, bus8.hi}; lo = {24'h0, bus8.lo};
         busy = bus8.busy; done = bus8.done; div0 = bus8.div0;
      end
   endtask

   // signed interpretation of the low w bits, then exact 64-bit arithmetic
   function automatic void model(input int w, input bit op, input logic [31:0] a,
                                 input logic [31:0] b, output logic [31:0] hi,
                                 output logic [31:0] lo, output bit dz);
      longint mask, sa, sb, p;
      mask = (longint'(1) << w) - 1;
      sa = longint'(a) & mask;
      sb = longint'(b) & mask;
      if (sa >= (longint'(1) << (w - 1))) sa = sa - (longint'(1) << w);
      if (sb >= (longint'(1) << (w - 1))) sb = sb - (longint'(1) << w);
      dz = 1'b0;
      hi = '0;
      lo = '0;
      if (!op) begin
         p  = sa * sb;
         hi = 32'((p >>> w) & mask);
         lo = 32'(p & mask);
      end else if (sb == 0) begin
         dz = 1'b1;
      end else begin
         hi = 32'((sa % sb) & mask);
         lo = 32'((sa / sb) & mask);
      end
   endfunction

   function automatic logic [31:0] rand_opnd(input int w);
      logic [31:0] v;
      case ($urandom_range(0, 7))
         0:       v = 32'h0;
         1:       v = 32'h1;
         2:       v = 32'hFFFF_FFFF;
         3:       v = 32'h1 << (w - 1);
         default: v = $urandom;
      endcase
      if (w < 32) v = v & ((32'h1 << w) - 32'h1);
      return v;
   endfunction

   task automatic run_op(input int w, input bit op, input logic [31:0] a, input logic [31:0] b,
                         input bit poke, input string tag);
      logic [31:0] m_hi, m_lo, hi, lo;
      logic        busy, done, div0;
      bit          dz;
      int          ix, cyc, busy_cnt;
      ix = (w == 32) ? 0 : 1;
      model(w, op, a, b, m_hi, m_lo, dz);
      drive(w, 1'b1, op, a, b);
      tick();
      drive(w, 1'b0, 1'($urandom_range(0, 1)), $urandom, $urandom);
      rd(w, hi, lo, busy, done, div0);
      if (dz) begin
         chk({tag, "_flags"}, {busy, done, div0}, 3'b011);
         chk({tag, "_hi"}, hi, exp_hi[ix]);
         chk({tag, "_lo"}, lo, exp_lo[ix]);
      end else begin
         chk({tag, "_ack"}, {busy, done, div0}, 3'b100);
         cyc = 0;
         busy_cnt = 0;
         while (!done && cyc < 4 * w + 8) begin
            if (busy) busy_cnt++;
            if (poke && cyc == 5) drive(w, 1'b1, ~op, $urandom, $urandom | 32'h1);
            else if (poke && cyc == 6) drive(w, 1'b0, op, a, b);
            tick();
            cyc++;
            rd(w, hi, lo, busy, done, div0);
         end
         chk({tag, "_lat"}, 64'(cyc), 64'(w + 1));
         chk({tag, "_busycyc"}, 64'(busy_cnt), 64'(w + 1));
         chk({tag, "_fin"}, {busy, done, div0}, 3'b010);
         chk({tag, "_hi"}, hi, m_hi);
         chk({tag, "_lo"}, lo, m_lo);
         exp_hi[ix] = m_hi;
         exp_lo[ix] = m_lo;
      end
   endtask

   task automatic idle_watch(input int w, input int n, input string tag);
      logic [31:0] hi, lo;
      logic        busy, done, div0;
      int          pulses;
      pulses = 0;
      for (int i = 0; i < n; i++) begin
         tick();
         rd(w, hi, lo, busy, done, div0);
         if (done || busy) pulses++;
      end
      chk(tag, 64'(pulses), 64'd0);
   endtask

   initial begin
      exp_hi[0] = '0; exp_lo[0] = '0; exp_hi[1] = '0; exp_lo[1] = '0;
      drive(32, 1'b0, 1'b0, '0, '0);
      drive(8, 1'b0, 1'b0, '0, '0);
      rst = 1'b1;
      repeat (3) tick();
      chk("rst32", {bus32.hi, bus32.lo, bus32.busy, bus32.done, bus32.div0}, '0);
      chk("rst8", {bus8.hi, bus8.lo, bus8.busy, bus8.done, bus8.div0}, '0);
      rst = 1'b0;
      tick();

      run_op(32, 1'b0, 32'd7, 32'hFFFF_FFFD, 1'b0, "mul7x-3");
      chk("mul7x-3_hi_const", bus32.hi, 32'hFFFF_FFFF);
      chk("mul7x-3_lo_const", bus32.lo, 32'hFFFF_FFEB);
      tick();
      run_op(32, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, "div-7by2");
      chk("div-7by2_const", {bus32.hi, bus32.lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
      run_op(32, 1'b1, 32'd100, 32'd7, 1'b0, "div100by7");
      chk("div100by7_const", {bus32.hi, bus32.lo}, {32'd2, 32'd14});
      run_op(32, 1'b1, 32'd68, 32'd7, 1'b0, "preload");
      chk("preload_const", {bus32.hi, bus32.lo}, {32'd5, 32'd9});
      tick();
      run_op(32, 1'b1, 32'd123, 32'd0, 1'b0, "div0");
      chk("div0_keep_const", {bus32.hi, bus32.lo}, {32'd5, 32'd9});
      tick();
      chk("div0_pulse", {bus32.busy, bus32.done, bus32.div0}, 3'b000);
      run_op(32, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "minbym1");
      chk("minbym1_const", {bus32.hi, bus32.lo}, {32'h0, 32'h8000_0000});
      run_op(32, 1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, "minxmin");
      chk("minxmin_const", {bus32.hi, bus32.lo}, {32'h4000_0000, 32'h0});
      run_op(32, 1'b0, 32'd12345, 32'hFFFF_FD5A, 1'b1, "poke");
      idle_watch(32, 40, "poke_no2nd");
      run_op(32, 1'b0, 32'h1234_5678, 32'h0BAD_F00D, 1'b0, "b2b_first");
      run_op(32, 1'b1, 32'hDEAD_BEEF, 32'h0000_1357, 1'b0, "b2b_second");

      drive(32, 1'b1, 1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
      tick();
      drive(32, 1'b0, 1'b0, '0, '0);
      repeat (9) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst32", {bus32.hi, bus32.lo, bus32.busy, bus32.done, bus32.div0}, '0);
      chk("midrst8", {bus8.hi, bus8.lo, bus8.busy, bus8.done, bus8.div0}, '0);
      exp_hi[0] = '0; exp_lo[0] = '0; exp_hi[1] = '0; exp_lo[1] = '0;
      idle_watch(32, 40, "midrst_nodone");

      run_op(8, 1'b0, 32'h81, 32'h03, 1'b0, "w8mul");
      chk("w8mul_const", {bus8.hi, bus8.lo}, {8'hFE, 8'h83});
      run_op(8, 1'b1, 32'h80, 32'hFF, 1'b0, "w8minbym1");
      chk("w8minbym1_const", {bus8.hi, bus8.lo}, {8'h00, 8'h80});

      for (int i = 0; i < 1000; i++)
         run_op(32, 1'($urandom_range(0, 1)), rand_opnd(32), rand_opnd(32), 1'b0, "rnd32");
      for (int i = 0; i < 1000; i++)
         run_op(8, 1'($urandom_range(0, 1)), rand_opnd(8), rand_opnd(8), 1'b0, "rnd8");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
